// File: rtl/i2c_cmd_sequencer.sv
// Command sequencer in front of the i2c master/slave top: queues host transactions,
// drives one level-sensitive request at a time and returns read data plus a timeout flag.
module i2c_cmd_sequencer #(
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4095
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rw,
    input  logic                    cmd_multi,
    input  logic [6:0]              cmd_chip,
    input  logic [8*ADDR_BYTES-1:0] cmd_reg,
    input  logic [8*DATA_BYTES-1:0] cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic                    i2c_enable,
    output logic [6:0]              i2c_chip,
    output logic [8*ADDR_BYTES-1:0] i2c_reg,
    output logic [8*DATA_BYTES-1:0] i2c_wdata,
    output logic                    i2c_write_en,
    output logic                    i2c_read_en,
    output logic                    i2c_mode,
    input  logic                    i2c_done,
    input  logic [8*DATA_BYTES-1:0] i2c_rdata
);

    localparam int RAW = 8 * ADDR_BYTES;
    localparam int DW  = 8 * DATA_BYTES;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    typedef struct packed {
        logic           rw;
        logic           multi;
        logic [6:0]     chip;
        logic [RAW-1:0] reg_addr;
        logic [DW-1:0]  wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LAUNCH,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

    cmd_t          r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    logic [15:0]   r_timer;
    logic          r_done_d;
    logic          r_cur_rw;
    logic          r_enable;
    logic [6:0]    r_chip;
    logic [RAW-1:0] r_reg;
    logic [DW-1:0] r_wdata;
    logic          r_mode;
    logic          r_write_en;
    logic          r_read_en;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_rdata;
    logic          r_rsp_err;

    cmd_t w_cmd_in;
    cmd_t w_head;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_done_rise;

    assign w_cmd_in    = '{rw: cmd_rw, multi: cmd_multi, chip: cmd_chip,
                           reg_addr: cmd_reg, wdata: cmd_wdata};
    assign w_head      = r_mem[r_rd_ptr];
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    // A full FIFO still takes a push on the cycle the head is popped.
    assign cmd_ready   = !w_full || w_pop;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_done_rise = i2c_done && !r_done_d;

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_done_d    <= 1'b0;
            r_cur_rw    <= 1'b0;
            r_enable    <= 1'b0;
            r_chip      <= '0;
            r_reg       <= '0;
            r_wdata     <= '0;
            r_mode      <= 1'b0;
            r_write_en  <= 1'b0;
            r_read_en   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_done_d <= i2c_done;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_enable <= 1'b1;
                        r_cur_rw <= w_head.rw;
                        r_chip   <= w_head.chip;
                        r_reg    <= w_head.reg_addr;
                        r_wdata  <= w_head.wdata;
                        r_mode   <= w_head.multi;
                        r_state  <= S_SETUP;
                    end else begin
                        r_enable <= 1'b0;
                    end
                end
                S_SETUP: r_state <= S_LAUNCH;
                S_LAUNCH: begin
                    r_read_en  <= r_cur_rw;
                    r_write_en <= !r_cur_rw;
                    r_timer    <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A done edge coinciding with the last timer cycle counts as success.
                    if (w_done_rise) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_cur_rw ? i2c_rdata : '0;
                        r_rsp_err   <= 1'b0;
                        r_write_en  <= 1'b0;
                        r_read_en   <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (r_timer == TIMER_LAST) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_write_en  <= 1'b0;
                        r_read_en   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_GAP;
                    end
                end
                S_GAP:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign i2c_enable   = r_enable;
    assign i2c_chip     = r_chip;
    assign i2c_reg      = r_reg;
    assign i2c_wdata    = r_wdata;
    assign i2c_write_en = r_write_en;
    assign i2c_read_en  = r_read_en;
    assign i2c_mode     = r_mode;

endmodule
